// File: rtl/fir_axis_out_buffer.sv
// FIR output stream buffer: 16-entry FWFT FIFO plus per-frame length checking.
// A beat pushed at edge N is visible after N and poppable at N+1; s_tready drops only when full.
module fir_axis_out_buffer #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH_LOG2 = 4,
  parameter int pLEN_WIDTH  = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic [pLEN_WIDTH-1:0]  cfg_len,
  input  logic                   err_clr,
  output logic                   frame_done,
  output logic                   len_err,
  output logic [15:0]            frame_cnt,
  output logic [pDEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << pDEPTH_LOG2;
  localparam logic [pDEPTH_LOG2:0] FULL_LVL = (pDEPTH_LOG2 + 1)'(DEPTH);

  logic [pDATA_WIDTH:0]    mem [DEPTH];
  logic [pDEPTH_LOG2-1:0]  wr_ptr;
  logic [pDEPTH_LOG2-1:0]  rd_ptr;
  logic [pDEPTH_LOG2:0]    level_q;
  logic                    run;
  logic [pLEN_WIDTH-1:0]   smp_cnt;
  logic [pLEN_WIDTH-1:0]   smp_next;
  logic                    push;
  logic                    pop;
  logic                    len_match;
  logic                    err_evt;

  // run keeps s_tready low while reset is asserted and for the first edge after release
  assign s_tready = run && (level_q != FULL_LVL);
  assign m_tvalid = (level_q != '0);
  assign level    = level_q;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  assign {m_tlast, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      run     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    smp_next  = (smp_cnt == '1) ? smp_cnt : smp_cnt + 1'b1;
    len_match = (smp_next == cfg_len);
    err_evt   = 1'b0;
    if (push && (cfg_len != '0)) begin
      // tlast must land exactly on cfg_len; reaching cfg_len without tlast is also an error
      err_evt = s_tlast ? !len_match : len_match;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      smp_cnt    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      len_err    <= 1'b0;
    end else begin
      frame_done <= push && s_tlast;
      if (push) begin
        if (s_tlast) begin
          smp_cnt   <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          smp_cnt <= smp_next;
        end
      end
      if (err_evt) begin
        len_err <= 1'b1;
      end else if (err_clr) begin
        len_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_axis_out_buffer.sv
// Bench for fir_axis_out_buffer: hand-computed vector table plus scoreboarded stream sequences.
module tb_fir_axis_out_buffer;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [31:0] cfg_len;
  logic        err_clr;
  logic        frame_done, len_err;
  logic [15:0] frame_cnt;
  logic [4:0]  level;

  fir_axis_out_buffer dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .cfg_len(cfg_len), .err_clr(err_clr), .frame_done(frame_done), .len_err(len_err),
    .frame_cnt(frame_cnt), .level(level)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        lst;
    logic        rdy;
    logic [31:0] len;
    logic        clr;
    logic [4:0]  e_lvl;
    logic        e_mv;
    logic [31:0] e_dat;
    logic        e_ml;
    logic        e_srdy;
    logic        e_fd;
    logic        e_le;
    logic [15:0] e_fc;
  } vec_t;

  vec_t        tbl [12];
  int          tests = 0;
  int          fails = 0;
  logic [32:0] q [$];
  logic [32:0] exp_beat;
  int          push_cnt = 0;
  int          fd_cnt = 0;
  int          max_lvl = 0;
  int          fc_exp = 0;
  logic        le_after, fd_after;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // One clock with the currently driven inputs; the scoreboard follows the handshakes.
  task automatic tick();
    logic pushed;
    pushed = s_tvalid && s_tready;
    if (m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_beat = q.pop_front();
        chk("pop_beat", {m_tlast, m_tdata}, exp_beat);
      end
    end
    if (pushed) begin
      q.push_back({s_tlast, s_tdata});
      push_cnt++;
      if (s_tlast) fc_exp = (fc_exp + 1) % 65536;
    end
    @(posedge axis_clk);
    #1;
    chk("level", level, q.size());
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (frame_done) fd_cnt++;
    if (pushed) begin
      le_after = len_err;
      fd_after = frame_done;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit done;
    done = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int k = 0; k < 50 && !done; k++) begin
      done = s_tready;
      tick();
    end
    if (!done) chk("push_timeout", 0, 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int k = 0; k < 100 && q.size() > 0; k++) tick();
    chk("drain_empty", q.size(), 0);
    tick();
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) send_beat(base + i, i == n - 1);
  endtask

  initial begin
    int acc0;
    //          vld  dat           lst  rdy  len    clr   lvl  mv  dat           ml  srdy fd  le  fc
    tbl[0]  = '{1'b1, 32'h0000_0A01, 1'b0, 1'b0, 32'd3, 1'b0, 5'd1, 1'b1, 32'h0000_0A01, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 32'h0000_0A02, 1'b0, 1'b0, 32'd3, 1'b0, 5'd2, 1'b1, 32'h0000_0A01, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 32'h0000_0A03, 1'b1, 1'b0, 32'd3, 1'b0, 5'd3, 1'b1, 32'h0000_0A01, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd3, 1'b0, 5'd3, 1'b1, 32'h0000_0A01, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'd3, 1'b0, 5'd2, 1'b1, 32'h0000_0A02, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 32'h0000_0B01, 1'b1, 1'b1, 32'd3, 1'b0, 5'd2, 1'b1, 32'h0000_0A03, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[6]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'd3, 1'b1, 5'd1, 1'b1, 32'h0000_0B01, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[7]  = '{1'b1, 32'h0000_0C01, 1'b0, 1'b0, 32'd1, 1'b1, 5'd2, 1'b1, 32'h0000_0B01, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    tbl[8]  = '{1'b1, 32'h0000_0C02, 1'b1, 1'b1, 32'd0, 1'b0, 5'd2, 1'b1, 32'h0000_0C01, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3};
    tbl[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'd0, 1'b1, 5'd1, 1'b1, 32'h0000_0C02, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[11] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};

    axis_rst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    m_tready = 1'b0; cfg_len = '0; err_clr = 1'b0;
    #12;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_level", level, 0);
    chk("rst_m_tdata", {m_tlast, m_tdata}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_len_err", {len_err, frame_done}, 0);
    axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;
    chk("post_rst_s_tready", s_tready, 1);

    for (int i = 0; i < 12; i++) begin
      s_tvalid = tbl[i].vld; s_tdata = tbl[i].dat; s_tlast = tbl[i].lst;
      m_tready = tbl[i].rdy; cfg_len = tbl[i].len; err_clr = tbl[i].clr;
      @(posedge axis_clk); #1;
      chk($sformatf("t%0d_level", i), level, tbl[i].e_lvl);
      chk($sformatf("t%0d_m_tvalid", i), m_tvalid, tbl[i].e_mv);
      chk($sformatf("t%0d_m_tdata", i), m_tdata, tbl[i].e_dat);
      chk($sformatf("t%0d_m_tlast", i), m_tlast, tbl[i].e_ml);
      chk($sformatf("t%0d_s_tready", i), s_tready, tbl[i].e_srdy);
      chk($sformatf("t%0d_frame_done", i), frame_done, tbl[i].e_fd);
      chk($sformatf("t%0d_len_err", i), len_err, tbl[i].e_le);
      chk($sformatf("t%0d_frame_cnt", i), frame_cnt, tbl[i].e_fc);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; err_clr = 1'b0;
    fc_exp = 3;

    // Pass-through of a full-length frame with the consumer always ready.
    cfg_len = 32'd600; m_tready = 1'b1; fd_cnt = 0; max_lvl = 0;
    send_frame(600, 32'd0);
    drain();
    chk("pt_frame_done_cnt", fd_cnt, 1);
    chk("pt_frame_cnt", frame_cnt, fc_exp);
    chk("pt_len_err", len_err, 0);
    chk("pt_max_level", max_lvl <= 1, 1);

    // Fill to full under back-pressure, then release one beat.
    cfg_len = 32'd0; m_tready = 1'b0; acc0 = push_cnt;
    for (int i = 0; i < 20; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'd1000 + i; s_tlast = (i == 15);
      tick();
    end
    chk("bp_accepted", push_cnt - acc0, 16);
    chk("bp_full_level", level, 16);
    chk("bp_full_s_tready", s_tready, 0);
    m_tready = 1'b1;
    tick();
    chk("bp_pop_level", level, 15);
    chk("bp_pop_s_tready", s_tready, 1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain();
    chk("bp_frame_cnt", frame_cnt, fc_exp);

    // Sustained simultaneous push/pop at level 8.
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(32'd2000 + i, 1'b0);
    chk("sim_fill_level", level, 8);
    m_tready = 1'b1;
    for (int i = 8; i < 18; i++) send_beat(32'd2000 + i, i == 17);
    chk("sim_hold_level", level, 8);
    drain();

    // Short frame: tlast one beat early.
    cfg_len = 32'd11; m_tready = 1'b1;
    send_frame(10, 32'd3000);
    chk("le_short_err", le_after, 1);
    chk("le_short_fd", fd_after, 1);
    chk("le_short_frame_cnt", frame_cnt, fc_exp);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("le_clr", len_err, 0);
    send_frame(11, 32'd3100);
    chk("le_good_err", le_after, 0);
    chk("le_good_fd", fd_after, 1);

    // Missing tlast: cfg_len=4 but frame is 6 beats.
    cfg_len = 32'd4; fd_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      send_beat(32'd3200 + i, i == 6);
      if (i == 3) chk("mt_b3_err", le_after, 0);
      if (i == 4) chk("mt_b4_err", le_after, 1);
      if (i < 6)  chk($sformatf("mt_b%0d_fd", i), fd_after, 0);
      if (i == 6) chk("mt_b6_fd", fd_after, 1);
    end
    drain();
    chk("mt_fd_cnt", fd_cnt, 1);
    chk("mt_frame_cnt", frame_cnt, fc_exp);

    // Asynchronous reset in the middle of a frame with 3 beats buffered.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    cfg_len = 32'd600; m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(32'd4000 + i, 1'b0);
    m_tready = 1'b1; tick(); tick(); m_tready = 1'b0;
    chk("rm_level_before", level, 3);
    #2 axis_rst_n = 1'b0;
    #1;
    chk("rm_m_tvalid", m_tvalid, 0);
    chk("rm_level", level, 0);
    chk("rm_frame_cnt", frame_cnt, 0);
    chk("rm_s_tready", s_tready, 0);
    q.delete(); fc_exp = 0;
    #2 axis_rst_n = 1'b1;
    m_tready = 1'b1; fd_cnt = 0;
    send_frame(600, 32'd5000);
    drain();
    chk("rm_frame_len_err", len_err, 0);
    chk("rm_frame_cnt_after", frame_cnt, 1);
    chk("rm_fd_cnt", fd_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_axis_out_buffer.md
Name: fir_axis_out_buffer

Overview:
- Downstream stage of the FIR engine. Consumes the FIR AXI-Stream master output (sm_tdata/sm_tvalid/sm_tlast) and buffers it in a small FIFO with first-word fall-through.
- Decouples FIR throughput from consumer back-pressure.
- Checks each frame's sample count against the programmed data length (same value written to FIR register 0x10) and reports frame completion and length errors as status.

Parameters:
- pDATA_WIDTH, 32, stream data width.
- pDEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries).
- pLEN_WIDTH, 32, width of cfg_len and of the per-frame sample counter.

Ports:
- axis_clk  in  1  clock.
- axis_rst_n  in  1  reset; asynchronous assert, active-low.
- s_tvalid  in  1  input stream valid (from FIR sm_tvalid).
- s_tready  out  1  input stream ready (to FIR sm_tready).
- s_tdata  in  pDATA_WIDTH  input sample.
- s_tlast  in  1  last sample of frame.
- m_tvalid  out  1  output stream valid.
- m_tready  in  1  output stream ready.
- m_tdata  out  pDATA_WIDTH  output sample.
- m_tlast  out  1  last flag, carried through the FIFO with its sample.
- cfg_len  in  pLEN_WIDTH  expected samples per frame; 0 disables checking.
- err_clr  in  1  synchronous clear of len_err.
- frame_done  out  1  one-cycle pulse on an accepted input beat with s_tlast=1.
- len_err  out  1  sticky frame-length mismatch flag.
- frame_cnt  out  16  count of completed input frames; wraps at 0xFFFF->0.
- level  out  pDEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async, axis_rst_n=0):
  - Outputs: m_tvalid=0, s_tready=0, m_tdata=0, m_tlast=0, frame_done=0, len_err=0, frame_cnt=0, level=0.
  - Internal state: read/write pointers 0, sample counter 0.
  - Reset mid-frame discards all FIFO contents and the partial count.
- s_tready:
  - After reset release, s_tready = (level != DEPTH), driven directly from the registered level.
  - s_tready=0 during reset.
- Handshakes:
  - Push = s_tvalid & s_tready.
  - Pop = m_tvalid & m_tready.
  - Payload {s_tlast, s_tdata} is stored per entry.
- FWFT output:
  - m_tvalid = (level != 0).
  - m_tdata/m_tlast present the entry at the read pointer.
  - Latency: a sample pushed at clock edge N is presented with m_tvalid=1 after edge N, and is poppable at edge N+1.
  - m_tdata must hold stable while m_tvalid=1 and m_tready=0.
- Level update:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged, both pointers advance.
  - When full, s_tready=0, so no push occurs even if a pop happens that cycle; s_tready rises the following cycle.
  - When empty, m_tvalid=0 and any m_tready is ignored.
- Pointers: wrap modulo DEPTH.
- Length check (evaluated only on a push):
  - n = sample counter + 1.
  - If s_tlast=1: pulse frame_done next cycle; frame_cnt += 1; counter reset to 0. If cfg_len != 0 and n != cfg_len, set len_err.
  - If s_tlast=0: counter = n. If cfg_len != 0 and n == cfg_len, set len_err (missing tlast); counting continues.
  - Counter saturates at all-ones.
  - cfg_len is sampled each beat; changing it mid-frame is legal but undefined for that frame's check.
- err_clr:
  - Clears len_err next cycle.
  - If err_clr and a new error event occur in the same cycle, the set wins.
- frame_done: asserted exactly one cycle per frame; never asserted on cycles without a push.

Test Plan:
- Pass-through: cfg_len=600, m_tready=1, push 600 samples 0..599 with tlast on #599.
  - Output is identical in order, m_tlast only on #599.
  - One frame_done pulse; frame_cnt=1; len_err=0; level never exceeds 1.
- Back-pressure/full: m_tready=0, push 20 beats.
  - 16 accepted; s_tready=0 with level=16.
  - Then m_tready=1 for one cycle: level=15 and s_tready=1 next cycle; no data lost or duplicated.
- Simultaneous push/pop at level=8 for 10 cycles.
  - Level stays 8; output sequence is contiguous.
- Length error:
  - cfg_len=11, tlast on beat 10 -> len_err=1 one cycle after beat 10; frame_cnt=1.
  - err_clr -> len_err=0.
  - Next frame of 11 beats with tlast on beat 11 -> len_err stays 0.
- Missing tlast: cfg_len=4, 6 beats with tlast on beat 6.
  - len_err set after beat 4; frame_done only after beat 6.
- Reset mid-frame: after 5 beats, with 3 buffered, assert axis_rst_n=0 asynchronously.
  - m_tvalid=0 and level=0 immediately; frame_cnt=0.
  - A fresh 600-beat frame afterwards passes with len_err=0.
